// File: rtl/game_screen_ctrl.sv
// -----------------------------------------------------------------------------
// game_screen_ctrl
//
// Top-level screen/game sequencer for the breakout design. Owns the game state
// machine (START, SERVE, PLAY, PAUSE, OVER, WIN), the lives counter and the
// frame-based timers, and picks which renderer's RGB565 pixel reaches the VGA
// output on every pixel clock.
//
// Ports:
//   clk           pixel clock
//   rst           asynchronous reset, active-high
//   xcnt, ycnt    current pixel column / line from the VGA timing generator
//   frame_tick    one-cycle pulse per frame at the start of vertical blank
//   btn_start     raw asynchronous start/pause button, active-high
//   ball_lost     one-cycle pulse: ball left the bottom edge
//   bricks_clear  one-cycle pulse: last brick destroyed
//   start_rgb     start-screen renderer pixel
//   play_rgb      playfield renderer pixel
//   msg_rgb       game-over / win message renderer pixel
//   rgb565        registered output pixel
//   state         current state: START=0 SERVE=1 PLAY=2 PAUSE=3 OVER=4 WIN=5
//   game_en       high only in PLAY; enables ball/paddle motion
//   game_init     one-cycle pulse: reload bricks, paddle and ball
//   ball_reset    one-cycle pulse: re-centre the ball after a life is lost
//   lives         remaining lives
// -----------------------------------------------------------------------------
module game_screen_ctrl #(
  parameter int unsigned LIVES        = 3,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned BLINK_FRAMES = 30,
  parameter int unsigned HOLD_FRAMES  = 180,
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned V_ACTIVE     = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  xcnt,
  input  logic [9:0]  ycnt,
  input  logic        frame_tick,
  input  logic        btn_start,
  input  logic        ball_lost,
  input  logic        bricks_clear,
  input  logic [15:0] start_rgb,
  input  logic [15:0] play_rgb,
  input  logic [15:0] msg_rgb,
  output logic [15:0] rgb565,
  output logic [2:0]  state,
  output logic        game_en,
  output logic        game_init,
  output logic        ball_reset,
  output logic [1:0]  lives
);

  typedef enum logic [2:0] {
    StStart = 3'd0,
    StServe = 3'd1,
    StPlay  = 3'd2,
    StPause = 3'd3,
    StOver  = 3'd4,
    StWin   = 3'd5
  } state_e;

  localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(HOLD_FRAMES - 1);
  localparam logic [1:0] LIVES_INIT = 2'(LIVES);
  localparam logic [9:0] H_LIMIT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_LIMIT    = 10'(V_ACTIVE);

  state_e      state_q;
  logic [7:0]  frame_cnt_q;
  logic        blink_q;
  logic [1:0]  lives_q;
  logic        game_en_q;
  logic        game_init_q;
  logic        ball_reset_q;
  logic [15:0] rgb_q;

  // ---------------------------------------------------------------------------
  // Button synchronizer and rising-edge detector
  // ---------------------------------------------------------------------------
  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic start_rise_q;

  // The rise is registered once more so a press sampled at edge n moves the
  // FSM at edge n+3. Holding the button yields a single rise because prev_q
  // follows sync2_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      prev_q       <= 1'b0;
      start_rise_q <= 1'b0;
    end else begin
      sync1_q      <= btn_start;
      sync2_q      <= sync1_q;
      prev_q       <= sync2_q;
      start_rise_q <= sync2_q & ~prev_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame counter helpers
  // ---------------------------------------------------------------------------
  logic [7:0] frame_cnt_inc;
  logic       serve_done;
  logic       hold_done;
  logic       blink_wrap;

  always_comb begin
    frame_cnt_inc = frame_cnt_q;
    if (frame_tick && (frame_cnt_q != 8'hFF)) begin
      frame_cnt_inc = frame_cnt_q + 8'd1;
    end
    serve_done = frame_tick && (frame_cnt_q == SERVE_LAST);
    hold_done  = frame_tick && (frame_cnt_q == HOLD_LAST);
    blink_wrap = frame_tick && (frame_cnt_q == BLINK_LAST);
  end

  // ---------------------------------------------------------------------------
  // Game state machine with registered outputs
  // ---------------------------------------------------------------------------
  // Default assignments come first; any transition overrides frame_cnt_q with
  // zero afterwards, so a coincident frame_tick clears rather than counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StStart;
      frame_cnt_q  <= 8'd0;
      blink_q      <= 1'b1;
      lives_q      <= 2'd0;
      game_en_q    <= 1'b0;
      game_init_q  <= 1'b0;
      ball_reset_q <= 1'b0;
    end else begin
      frame_cnt_q  <= frame_cnt_inc;
      game_en_q    <= (state_q == StPlay);
      game_init_q  <= 1'b0;
      ball_reset_q <= 1'b0;

      case (state_q)
        StStart: begin
          if (start_rise_q) begin
            state_q     <= StServe;
            frame_cnt_q <= 8'd0;
            lives_q     <= LIVES_INIT;
            game_init_q <= 1'b1;
            game_en_q   <= 1'b0;
          end else if (blink_wrap) begin
            blink_q     <= ~blink_q;
            frame_cnt_q <= 8'd0;
          end
        end

        StServe: begin
          if (serve_done) begin
            state_q     <= StPlay;
            frame_cnt_q <= 8'd0;
            game_en_q   <= 1'b1;
          end
        end

        StPlay: begin
          if (bricks_clear) begin
            state_q     <= StWin;
            frame_cnt_q <= 8'd0;
            game_en_q   <= 1'b0;
          end else if (ball_lost) begin
            frame_cnt_q <= 8'd0;
            game_en_q   <= 1'b0;
            if (lives_q <= 2'd1) begin
              state_q <= StOver;
              lives_q <= 2'd0;
            end else begin
              state_q      <= StServe;
              lives_q      <= lives_q - 2'd1;
              ball_reset_q <= 1'b1;
            end
          end else if (start_rise_q) begin
            state_q     <= StPause;
            frame_cnt_q <= 8'd0;
            game_en_q   <= 1'b0;
          end
        end

        StPause: begin
          if (start_rise_q) begin
            state_q     <= StPlay;
            frame_cnt_q <= 8'd0;
            game_en_q   <= 1'b1;
          end
        end

        StOver, StWin: begin
          if (hold_done) begin
            state_q     <= StStart;
            frame_cnt_q <= 8'd0;
            blink_q     <= 1'b1;
          end
        end

        default: begin
          // Unused encodings recover to the start screen.
          state_q     <= StStart;
          frame_cnt_q <= 8'd0;
          game_en_q   <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Pixel mux
  // ---------------------------------------------------------------------------
  logic        in_active;
  logic [15:0] pause_rgb;
  logic [15:0] pix_d;

  // Each RGB565 channel shifted right by one: half brightness while paused.
  assign pause_rgb = {1'b0, play_rgb[15:12], 1'b0, play_rgb[10:6], 1'b0, play_rgb[4:1]};
  assign in_active = (xcnt < H_LIMIT) && (ycnt < V_LIMIT);

  always_comb begin
    pix_d = 16'h0000;
    if (in_active) begin
      case (state_q)
        StStart:        pix_d = blink_q ? start_rgb : 16'h0000;
        StServe,
        StPlay:         pix_d = play_rgb;
        StPause:        pix_d = pause_rgb;
        StOver,
        StWin:          pix_d = msg_rgb;
        default:        pix_d = 16'h0000;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_q <= 16'h0000;
    end else begin
      rgb_q <= pix_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign rgb565     = rgb_q;
  assign state      = state_q;
  assign game_en    = game_en_q;
  assign game_init  = game_init_q;
  assign ball_reset = ball_reset_q;
  assign lives      = lives_q;

endmodule
